// File: rtl/us_arp_cache.sv
// Multi-entry ARP cache: learns {IP, MAC} pairs from ARP traffic, ages them out,
// resolves the destination IP in one cycle and drives a retrying ARP request engine.
module us_arp_cache #(
    parameter int unsigned ENTRIES            = 4,
    parameter logic [31:0] AGE_CYCLES         = 32'd2500000000,
    parameter logic [31:0] REQ_TIMEOUT_CYCLES = 32'd156250000,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     arp_valid,
    input  logic [31:0]              recv_src_ip_addr,
    input  logic [47:0]              recv_src_mac_addr,
    input  logic [31:0]              dst_ip_addr,
    output logic [47:0]              dst_mac_addr,
    output logic                     arp_mac_exist,
    output logic                     arp_request_req,
    input  logic                     arp_request_ack,
    output logic [31:0]              arp_request_ip,
    output logic                     arp_fail,
    output logic [$clog2(ENTRIES):0] entries_used
);

    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam int unsigned CNT_W   = IDX_W + 1;
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_e;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [31:0]        ip_q  [ENTRIES];
    logic [31:0]        ip_d  [ENTRIES];
    logic [47:0]        mac_q [ENTRIES];
    logic [47:0]        mac_d [ENTRIES];
    logic [31:0]        age_q [ENTRIES];
    logic [31:0]        age_d [ENTRIES];
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               wr_ok_c;
    logic               match_c;
    logic               free_c;
    logic [IDX_W-1:0]   match_idx_c;
    logic [IDX_W-1:0]   free_idx_c;
    logic [IDX_W-1:0]   wr_idx_c;

    logic               hit_c;
    logic [47:0]        hit_mac_c;
    logic [CNT_W-1:0]   used_c;

    logic [47:0]        dst_mac_q;
    logic               exist_q;
    logic [CNT_W-1:0]   used_q;

    state_e             state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [31:0]        timer_q, timer_d;
    logic [31:0]        req_ip_q, req_ip_d;
    logic               req_q;
    logic               fail_q;
    logic               fail_c;

    // Write target: refresh a matching IP, else the lowest free slot, else round-robin victim.
    always_comb begin
        wr_ok_c     = arp_valid && !flush
                      && (recv_src_ip_addr != 32'd0)
                      && (recv_src_mac_addr != 48'hFFFF_FFFF_FFFF)
                      && (recv_src_mac_addr != 48'd0);
        match_c     = 1'b0;
        free_c      = 1'b0;
        match_idx_c = '0;
        free_idx_c  = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!match_c && valid_q[i] && (ip_q[i] == recv_src_ip_addr)) begin
                match_c     = 1'b1;
                match_idx_c = IDX_W'(i);
            end
            if (!free_c && !valid_q[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
        if (match_c) begin
            wr_idx_c = match_idx_c;
        end else if (free_c) begin
            wr_idx_c = free_idx_c;
        end else begin
            wr_idx_c = ptr_q;
        end
    end

    // Table next state: aging first so a same-cycle write to an expiring entry wins.
    always_comb begin
        valid_d = valid_q;
        ip_d    = ip_q;
        mac_d   = mac_q;
        age_d   = age_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[i]) begin
                if (age_q[i] == AGE_CYCLES - 32'd1) begin
                    valid_d[i] = 1'b0;
                end else begin
                    age_d[i] = age_q[i] + 32'd1;
                end
            end
        end
        if (wr_ok_c) begin
            valid_d[wr_idx_c] = 1'b1;
            ip_d[wr_idx_c]    = recv_src_ip_addr;
            mac_d[wr_idx_c]   = recv_src_mac_addr;
            age_d[wr_idx_c]   = 32'd0;
            if (!match_c && !free_c) begin
                ptr_d = (ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : ptr_q + IDX_W'(1);
            end
        end
        if (flush) begin
            valid_d = '0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ip_q[i]  <= 32'd0;
                mac_q[i] <= 48'd0;
                age_q[i] <= 32'd0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            ip_q    <= ip_d;
            mac_q   <= mac_d;
            age_q   <= age_d;
        end
    end

    // Parallel lookup, lowest index wins; also the valid-entry population count.
    always_comb begin
        hit_c     = 1'b0;
        hit_mac_c = 48'hFFFF_FFFF_FFFF;
        used_c    = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!hit_c && valid_q[i] && (dst_ip_addr != 32'd0) && (ip_q[i] == dst_ip_addr)) begin
                hit_c     = 1'b1;
                hit_mac_c = mac_q[i];
            end
            used_c = used_c + CNT_W'(valid_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dst_mac_q <= 48'hFFFF_FFFF_FFFF;
            exist_q   <= 1'b0;
            used_q    <= '0;
        end else begin
            dst_mac_q <= hit_mac_c;
            exist_q   <= hit_c;
            used_q    <= used_c;
        end
    end

    // Request engine next state.
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        req_ip_d = req_ip_q;
        fail_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!exist_q && (dst_ip_addr != 32'd0)) begin
                    state_d  = ST_REQ;
                    req_ip_d = dst_ip_addr;
                    retry_d  = '0;
                end
            end
            ST_REQ: begin
                if (arp_request_ack) begin
                    state_d = ST_WAIT;
                    timer_d = 32'd0;
                end
            end
            ST_WAIT: begin
                // Once dst equals the queried IP, a current hit means it was resolved.
                if ((dst_ip_addr != req_ip_q) || hit_c) begin
                    state_d = ST_IDLE;
                end else if (timer_q == REQ_TIMEOUT_CYCLES - 32'd1) begin
                    if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_REQ;
                    end else begin
                        fail_c  = 1'b1;
                        state_d = ST_HOLD;
                        timer_d = 32'd0;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_HOLD: begin
                if (timer_q == REQ_TIMEOUT_CYCLES - 32'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            retry_q  <= '0;
            timer_q  <= 32'd0;
            req_ip_q <= 32'd0;
            req_q    <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            req_ip_q <= req_ip_d;
            req_q    <= (state_d == ST_REQ);
            fail_q   <= fail_c;
        end
    end

    assign dst_mac_addr    = dst_mac_q;
    assign arp_mac_exist   = exist_q;
    assign entries_used    = used_q;
    assign arp_request_req = req_q;
    assign arp_request_ip  = req_ip_q;
    assign arp_fail        = fail_q;

endmodule

// File: tb/tb_us_arp_cache.sv
// Scoreboard bench for us_arp_cache: directed stimulus queues time-stamped expectations,
// a negedge monitor retires them against the DUT outputs.
module tb_us_arp_cache;

    localparam int unsigned ENTRIES = 4;
    localparam logic [31:0] AGE     = 32'd1000;
    localparam logic [31:0] TMO     = 32'd100;
    localparam int unsigned MAXR    = 2;

    localparam int K_LOOK    = 0;
    localparam int K_USED    = 1;
    localparam int K_REQ     = 2;
    localparam int K_FAIL    = 3;
    localparam int K_RIP     = 4;
    localparam int K_REQCNT  = 5;
    localparam int K_FAILCNT = 6;

    localparam logic [63:0] MISS = {15'd0, 1'b0, 48'hFFFF_FFFF_FFFF};

    typedef struct {
        int unsigned due;
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        arp_valid = 1'b0;
    logic [31:0] recv_ip = 32'd0;
    logic [47:0] recv_mac = 48'd0;
    logic [31:0] dst_ip = 32'd0;
    logic [47:0] dst_mac;
    logic        mac_exist;
    logic        req;
    logic        ack = 1'b0;
    logic [31:0] req_ip;
    logic        fail;
    logic [2:0]  used;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned req_rises = 0;
    int unsigned fail_pulses = 0;
    logic        req_prev = 1'b0;

    us_arp_cache #(
        .ENTRIES            (ENTRIES),
        .AGE_CYCLES         (AGE),
        .REQ_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .flush             (flush),
        .arp_valid         (arp_valid),
        .recv_src_ip_addr  (recv_ip),
        .recv_src_mac_addr (recv_mac),
        .dst_ip_addr       (dst_ip),
        .dst_mac_addr      (dst_mac),
        .arp_mac_exist     (mac_exist),
        .arp_request_req   (req),
        .arp_request_ack   (ack),
        .arp_request_ip    (req_ip),
        .arp_fail          (fail),
        .entries_used      (used)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ARP TX stand-in: acknowledges every request three cycles after it is seen.
    initial forever begin
        @(negedge clk);
        if (req) begin
            repeat (3) @(posedge clk);
            #1 ack = 1'b1;
            @(posedge clk);
            #1 ack = 1'b0;
        end
    end

    function automatic logic [63:0] actual(input int kind);
        case (kind)
            K_LOOK:    return {15'd0, mac_exist, dst_mac};
            K_USED:    return 64'(used);
            K_REQ:     return 64'(req);
            K_FAIL:    return 64'(fail);
            K_RIP:     return 64'(req_ip);
            K_REQCNT:  return 64'(req_rises);
            K_FAILCNT: return 64'(fail_pulses);
            default:   return '1;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (req && !req_prev) req_rises++;
        req_prev = req;
        if (fail) fail_pulses++;
        for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
            logic [63:0] act;
            if (sb_q[i].due == cyc) begin
                act = actual(sb_q[i].kind);
                checks++;
                if (act !== sb_q[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             sb_q[i].name, act, sb_q[i].exp, cyc);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned lat, input int kind,
                             input logic [63:0] exp, input string name);
        exp_t e;
        e.due  = cyc + lat;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] ipn(input int n);
        return 32'hC0A8_0100 + 32'(n);
    endfunction

    function automatic logic [47:0] macn(input int n);
        return 48'h02AA_0000_0000 + 48'(n);
    endfunction

    function automatic logic [63:0] hit(input logic [47:0] m);
        return {15'd0, 1'b1, m};
    endfunction

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        arp_valid = 1'b1;
        recv_ip   = ip;
        recv_mac  = mac;
        tick();
        arp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        arp_valid = 1'b0;
        flush     = 1'b0;
        dst_ip    = 32'd0;
        recv_ip   = 32'd0;
        recv_mac  = 48'd0;
        repeat (8) tick();
        rstn = 1'b1;
        tick();
    endtask

    int unsigned base_r;
    int unsigned base_f;
    int unsigned t0;

    initial begin
        // Reset values
        do_reset();
        expect_at(0, K_LOOK, MISS, "rst_lookup");
        expect_at(0, K_USED, 64'd0, "rst_used");
        expect_at(0, K_REQ, 64'd0, "rst_req");
        expect_at(0, K_FAIL, 64'd0, "rst_fail");
        expect_at(0, K_RIP, 64'd0, "rst_req_ip");
        tick();

        // Learn and hit, with the lookup issued in the strobe cycle
        arp_valid = 1'b1;
        recv_ip   = 32'hC0A8_0165;
        recv_mac  = 48'hA036_9F7D_E58C;
        dst_ip    = 32'hC0A8_0165;
        expect_at(1, K_LOOK, MISS, "learn_not_yet");
        expect_at(2, K_LOOK, hit(48'hA036_9F7D_E58C), "learn_hit");
        expect_at(1, K_USED, 64'd0, "learn_used_before");
        expect_at(2, K_USED, 64'd1, "learn_used");
        expect_at(1, K_REQ, 64'd1, "learn_req_rise");
        expect_at(1, K_RIP, 64'(32'hC0A8_0165), "learn_req_ip");
        expect_at(6, K_REQ, 64'd0, "learn_req_fall");
        tick();
        arp_valid = 1'b0;
        repeat (10) tick();

        // Replacement: .5 evicts .1 at pointer 0, then .6 evicts .2 at pointer 1
        do_reset();
        for (int i = 1; i <= 5; i++) learn(ipn(i), macn(i));
        for (int i = 1; i <= 5; i++) begin
            dst_ip = ipn(i);
            expect_at(1, K_LOOK, (i == 1) ? MISS : hit(macn(i)), $sformatf("repl_lookup_%0d", i));
            if (i == 1) expect_at(1, K_USED, 64'd4, "repl_used");
            tick();
        end
        learn(ipn(6), macn(6));
        dst_ip = ipn(2);
        expect_at(1, K_LOOK, MISS, "ptr_victim_2");
        tick();
        dst_ip = ipn(6);
        expect_at(1, K_LOOK, hit(macn(6)), "ptr_new_6");
        tick();
        dst_ip = ipn(5);
        expect_at(1, K_LOOK, hit(macn(5)), "ptr_keep_5");
        tick();
        dst_ip = 32'd0;
        repeat (6) tick();

        // Refresh and aging: the refresh at +900 restarts the lifetime
        do_reset();
        t0     = cyc;
        dst_ip = ipn(7);
        learn(ipn(7), macn(70));
        while (cyc < t0 + 900) tick();
        arp_valid = 1'b1;
        recv_ip   = ipn(7);
        recv_mac  = macn(71);
        expect_at(0, K_LOOK, hit(macn(70)), "age_first_mac");
        expect_at(2, K_LOOK, hit(macn(71)), "age_new_mac");
        expect_at(102, K_LOOK, hit(macn(71)), "age_survives_first");
        expect_at(1001, K_LOOK, hit(macn(71)), "age_last_hit");
        expect_at(1002, K_LOOK, MISS, "age_expired");
        expect_at(1001, K_USED, 64'd1, "age_used_before");
        expect_at(1002, K_USED, 64'd0, "age_used_after");
        tick();
        arp_valid = 1'b0;
        while (cyc < t0 + 1905) tick();

        // Retry and fail: three requests, one fail pulse, quiet hold-off, restart
        do_reset();
        base_r = req_rises;
        base_f = fail_pulses;
        dst_ip = ipn(9);
        expect_at(1, K_REQ, 64'd1, "try1_rise");
        expect_at(104, K_REQ, 64'd0, "try1_wait");
        expect_at(105, K_REQ, 64'd1, "try2_rise");
        expect_at(208, K_REQ, 64'd0, "try2_wait");
        expect_at(209, K_REQ, 64'd1, "try3_rise");
        expect_at(312, K_FAIL, 64'd0, "fail_early");
        expect_at(313, K_FAIL, 64'd1, "fail_pulse");
        expect_at(314, K_FAIL, 64'd0, "fail_single");
        expect_at(313, K_REQCNT, 64'(base_r + 3), "req_count");
        expect_at(413, K_REQCNT, 64'(base_r + 3), "hold_quiet");
        expect_at(413, K_REQ, 64'd0, "hold_req_low");
        expect_at(414, K_REQ, 64'd1, "restart_rise");
        expect_at(420, K_FAILCNT, 64'(base_f + 1), "fail_count");
        repeat (421) tick();

        // Resolve during WAIT: learning the queried IP ends the request cycle
        do_reset();
        base_r = req_rises;
        base_f = fail_pulses;
        dst_ip = ipn(9);
        repeat (10) tick();
        expect_at(2, K_LOOK, hit(macn(9)), "resolve_hit");
        expect_at(95, K_REQ, 64'd0, "resolve_no_retry");
        expect_at(390, K_REQCNT, 64'(base_r + 1), "resolve_req_count");
        expect_at(390, K_FAILCNT, 64'(base_f), "resolve_no_fail");
        learn(ipn(9), macn(9));
        repeat (395) tick();

        // Invalid inputs and flush
        do_reset();
        dst_ip    = ipn(20);
        arp_valid = 1'b1;
        recv_ip   = ipn(20);
        recv_mac  = 48'hFFFF_FFFF_FFFF;
        expect_at(2, K_LOOK, MISS, "bcast_mac_lookup");
        tick();
        recv_ip  = 32'd0;
        recv_mac = macn(20);
        tick();
        recv_ip  = ipn(20);
        recv_mac = 48'd0;
        tick();
        recv_ip  = ipn(21);
        recv_mac = macn(21);
        flush    = 1'b1;
        tick();
        arp_valid = 1'b0;
        flush     = 1'b0;
        dst_ip    = ipn(21);
        expect_at(0, K_USED, 64'd0, "invalid_used");
        expect_at(1, K_USED, 64'd0, "flush_drop_used");
        expect_at(1, K_LOOK, MISS, "flush_drop_lookup");
        tick();
        dst_ip = ipn(30);
        expect_at(2, K_LOOK, hit(macn(30)), "preflush_hit");
        expect_at(2, K_USED, 64'd1, "preflush_used");
        learn(ipn(30), macn(30));
        tick();
        flush = 1'b1;
        expect_at(2, K_USED, 64'd0, "flush_used");
        expect_at(2, K_LOOK, MISS, "flush_lookup");
        tick();
        flush = 1'b0;
        repeat (6) tick();

        // Reset while a request is outstanding
        do_reset();
        dst_ip = ipn(9);
        tick();
        expect_at(0, K_REQ, 64'd1, "midreq_high");
        tick();
        rstn = 1'b0;
        expect_at(1, K_REQ, 64'd0, "midreq_reset_drop");
        tick();
        tick();
        do_reset();
        repeat (5) tick();

        foreach (sb_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never checked, expected %h at cycle %0d",
                     sb_q[i].name, sb_q[i].exp, sb_q[i].due);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
